morse_symbol_ctrl: RTL



---
 rtl/morse_pkg.sv | 27 ++
 rtl/morse_symbol_ctrl_if.sv | 20 ++
 rtl/morse_tick_gen.sv | 33 +++
 rtl/morse_symbol_ctrl.sv | 108 ++++++++++
 4 files changed

// File: rtl/morse_pkg.sv
// Shared types and constants for the Morse symbol timing path.
package morse_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    GAP   = 2'd2,
    EMIT  = 2'd3
  } state_t;

  localparam logic [2:0] SPEC_RST = 3'b011;
  localparam logic [2:0] SPEC_MIN = 3'd0;
  localparam logic [2:0] SPEC_MAX = 3'd6;

  localparam logic DOT  = 1'b0;
  localparam logic DASH = 1'b1;

  // Simultaneous up/down requests cancel; the result never leaves SPEC_MIN..SPEC_MAX.
  function automatic logic [2:0] spec_step(input logic [2:0] cur, input logic up, input logic dn);
    logic [2:0] nxt;
    nxt = cur;
    if (up && !dn && cur > SPEC_MIN) nxt = cur - 3'd1;
    if (dn && !up && cur < SPEC_MAX) nxt = cur + 3'd1;
    return nxt;
  endfunction

endpackage

// File: rtl/morse_symbol_ctrl_if.sv
// Completed-letter handoff from the symbol controller to the character decoder.
interface morse_symbol_ctrl_if #(
  parameter int unsigned MAX_SYMS = 5
);
  logic                letter_valid;
  logic                letter_ready;
  logic [MAX_SYMS-1:0] letter_bits;
  logic [2:0]          letter_len;
  logic                letter_err;

  modport master (
    output letter_valid, letter_bits, letter_len, letter_err,
    input  letter_ready
  );

  modport slave (
    input  letter_valid, letter_bits, letter_len, letter_err,
    output letter_ready
  );
endinterface

// File: rtl/morse_tick_gen.sv
// Divider rising-edge detector feeding a saturating tick counter with synchronous clear.
module morse_tick_gen #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_div_out,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_cnt
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             r_div_q;
  logic [CNT_W-1:0] r_cnt;
  logic             w_tick;

  assign w_tick = i_div_out & ~r_div_q;
  assign o_cnt  = r_cnt;

  // Clear wins over a coincident tick so a state change never counts that tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div_q <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_div_q <= i_div_out;
      if (i_clr)
        r_cnt <= '0;
      else if (w_tick && r_cnt != CNT_MAX)
        r_cnt <= r_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/morse_symbol_ctrl.sv
// Times key presses/gaps in divider ticks, classifies dots/dashes and hands off whole letters.
module morse_symbol_ctrl
  import morse_pkg::*;
#(
  parameter int unsigned DOT_MAX    = 2,
  parameter int unsigned LETTER_GAP = 3,
  parameter int unsigned MAX_SYMS   = 5,
  parameter int unsigned CNT_W      = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 key,
  input  logic                 speed_up,
  input  logic                 speed_dn,
  input  logic                 div_out,
  output logic [2:0]           spec,
  output logic                 sym_valid,
  output logic                 sym_dash,
  morse_symbol_ctrl_if.master  lb
);
  localparam logic [2:0] LEN_MAX = 3'(MAX_SYMS);

  state_t              r_state, w_state_nxt;
  logic [CNT_W-1:0]    w_cnt;
  logic                w_clr, w_rec, w_dash, w_hs;
  logic [MAX_SYMS-1:0] r_bits;
  logic [2:0]          r_len;
  logic                r_err;
  logic                r_sym_valid, r_sym_dash;
  logic [2:0]          r_spec;

  morse_tick_gen #(.CNT_W(CNT_W)) u_tick (
    .clk       (clk),
    .rst       (rst),
    .i_div_out (div_out),
    .i_clr     (w_clr),
    .o_cnt     (w_cnt)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_rec       = 1'b0;
    w_dash      = DOT;
    w_hs        = (r_state == EMIT) && lb.letter_ready;
    case (r_state)
      IDLE:  if (key) w_state_nxt = PRESS;
      PRESS: begin
        if (!key) begin
          if (w_cnt == '0) begin
            w_state_nxt = (r_len != 3'd0) ? GAP : IDLE;
          end else begin
            w_rec       = 1'b1;
            w_dash      = (w_cnt > CNT_W'(DOT_MAX)) ? DASH : DOT;
            w_state_nxt = GAP;
          end
        end
      end
      GAP: begin
        if (key)
          w_state_nxt = PRESS;
        else if (w_cnt == CNT_W'(LETTER_GAP))
          w_state_nxt = EMIT;
      end
      EMIT:  if (w_hs) w_state_nxt = key ? PRESS : IDLE;
      default: w_state_nxt = IDLE;
    endcase
    // Every state entry restarts timing from zero.
    w_clr = (w_state_nxt != r_state);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_bits      <= '0;
      r_len       <= 3'd0;
      r_err       <= 1'b0;
      r_sym_valid <= 1'b0;
      r_sym_dash  <= 1'b0;
      r_spec      <= SPEC_RST;
    end else begin
      r_state     <= w_state_nxt;
      r_sym_valid <= w_rec;
      r_sym_dash  <= w_rec & w_dash;
      if (w_hs) begin
        r_bits <= '0;
        r_len  <= 3'd0;
        r_err  <= 1'b0;
      end else if (w_rec) begin
        if (r_len < LEN_MAX) begin
          r_bits[r_len] <= w_dash;
          r_len         <= r_len + 3'd1;
        end else begin
          r_err <= 1'b1;
        end
      end
      if (r_state == IDLE)
        r_spec <= spec_step(r_spec, speed_up, speed_dn);
    end
  end

  assign spec            = r_spec;
  assign sym_valid       = r_sym_valid;
  assign sym_dash        = r_sym_dash;
  assign lb.letter_valid = (r_state == EMIT);
  assign lb.letter_bits  = r_bits;
  assign lb.letter_len   = r_len;
  assign lb.letter_err   = r_err;
endmodule
